// File: rtl/rr_decode_arbiter_if.sv
// rr_decode_arbiter_if: requester <-> arbiter bundle.
// Requesters drive en/req/done; the arbiter returns the grant.
interface rr_decode_arbiter_if;
  logic       en;
  logic [7:0] req;
  logic       done;
  logic       grant_valid;
  logic [2:0] grant_idx;
  logic [7:0] grant_oh;
  logic       timeout;

  modport master (
    output en, req, done,
    input  grant_valid, grant_idx,
    input  grant_oh, timeout
  );

  modport slave (
    input  en, req, done,
    output grant_valid, grant_idx,
    output grant_oh, timeout
  );
endinterface

// File: rtl/rr_decode_arbiter.sv
// rr_decode_arbiter: 8-way round-robin owner of a 3-to-8 select,
// with break-before-make gaps and an optional tenure limit.
module rr_decode_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  rr_decode_arbiter_if.slave arb
);
  localparam int unsigned HOLD_M1 =
    (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [7:0] HOLD_LAST = HOLD_M1[7:0];
  localparam logic HOLD_ON = (MAX_HOLD != 0);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] oh_q, oh_d;
  logic [7:0] ten_q, ten_d;
  logic       to_q, to_d;

  logic [2:0] win;
  logic [2:0] cand;
  logic       found;
  logic       hold_hit;
  logic       drop;
  logic       rel;

  function automatic logic [3:0] dec2to4(
    input logic [1:0] s
  );
    dec2to4 = 4'b0001 << s;
  endfunction

  // Two 2-to-4 halves, the upper select bit picks which one fires.
  function automatic logic [7:0] dec3to8(
    input logic [2:0] s
  );
    logic [3:0] lo;
    lo = dec2to4(s[1:0]);
    dec3to8 = '0;
    unique case (1'b1)
      s[2]:  dec3to8 = {lo, 4'b0000};
      !s[2]: dec3to8 = {4'b0000, lo};
      default: ;
    endcase
  endfunction

  always_comb begin
    win   = ptr_q;
    cand  = ptr_q;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cand = ptr_q + 3'(i);
      if (!found && arb.req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  assign hold_hit = HOLD_ON && (ten_q == HOLD_LAST);
  assign drop     = !arb.req[idx_q];
  assign rel      = arb.done || drop || hold_hit;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    oh_d    = oh_q;
    ten_d   = ten_q;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb.en && found) begin
          state_d = GRANT;
          idx_d   = win;
          oh_d    = dec3to8(win);
          ten_d   = '0;
          ptr_d   = win + 3'd1;
        end
      end
      GRANT: begin
        if (rel) begin
          state_d = IDLE;
          oh_d    = '0;
          // Limit only counts as timeout if nothing else released.
          to_d    = hold_hit && !arb.done && !drop;
        end else begin
          ten_d = ten_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      oh_q    <= '0;
      ten_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      oh_q    <= oh_d;
      ten_q   <= ten_d;
      to_q    <= to_d;
    end
  end

  assign arb.grant_valid = (state_q == GRANT);
  assign arb.grant_idx   = idx_q;
  assign arb.grant_oh    = oh_q;
  assign arb.timeout     = to_q;

endmodule
